// File: rtl/e203_ifu_flush_ctrl_pkg.sv
// Shared definitions for the IFU flush-redirect controller: PC width and FSM state encoding.
package e203_ifu_flush_ctrl_pkg;

    localparam int E203_PC_SIZE = 32;

    typedef enum logic [1:0] {
        IFC_IDLE     = 2'd0,
        IFC_DRAIN    = 2'd1,
        IFC_REDIRECT = 2'd2
    } ifc_state_e;

endpackage

// File: rtl/e203_ifu_flush_cnt.sv
// Saturating event counter used to count accepted pipeline flushes.
module e203_ifu_flush_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_sat;

    assign w_sat   = &r_count;
    assign o_count = r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !w_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/e203_ifu_flush_ctrl.sv
// Flush-redirect controller: accepts a commit flush, drains outstanding fetches while
// killing their responses, then hands the redirect PC to the PC generator.
module e203_ifu_flush_ctrl
    import e203_ifu_flush_ctrl_pkg::*;
#(
    parameter int PC_SIZE      = E203_PC_SIZE,
    parameter int USE_FLUSH_PC = 0,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_flush_req,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
    input  logic [PC_SIZE-1:0] pipe_flush_pc,
    output logic               pipe_flush_ack,
    input  logic               ifu_rsp_pending,
    output logic               ifu_hold,
    output logic               ifu_rsp_kill,
    output logic               redirect_valid,
    output logic [PC_SIZE-1:0] redirect_pc,
    input  logic               redirect_ready,
    output logic [CNT_W-1:0]   flush_count
);

    ifc_state_e         r_state;
    ifc_state_e         w_state_nxt;
    logic [PC_SIZE-1:0] r_pc;
    logic [PC_SIZE-1:0] w_target;
    logic               w_accept;

    // Adder carry is dropped on purpose: the target wraps modulo 2^PC_SIZE.
    assign w_target = (USE_FLUSH_PC != 0) ? pipe_flush_pc
                                          : (pipe_flush_add_op1 + pipe_flush_add_op2);
    assign w_accept    = pipe_flush_req & pipe_flush_ack;
    assign redirect_pc = r_pc;

    // NOTE: every output and next-state is defaulted first so no path leaves a latch.
    always_comb begin
        w_state_nxt    = r_state;
        pipe_flush_ack = 1'b0;
        ifu_hold       = 1'b1;
        ifu_rsp_kill   = 1'b1;
        redirect_valid = 1'b0;
        case (r_state)
            IFC_IDLE: begin
                pipe_flush_ack = 1'b1;
                ifu_hold       = 1'b0;
                ifu_rsp_kill   = 1'b0;
                if (pipe_flush_req) begin
                    w_state_nxt = IFC_DRAIN;
                end
            end
            IFC_DRAIN: begin
                if (!ifu_rsp_pending) begin
                    w_state_nxt = IFC_REDIRECT;
                end
            end
            IFC_REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    w_state_nxt = IFC_IDLE;
                end
            end
            default: begin
                w_state_nxt = IFC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IFC_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_pc <= w_target;
            end
        end
    end

    e203_ifu_flush_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_accept),
        .o_count (flush_count)
    );

endmodule

// File: tb/tb_e203_ifu_flush_ctrl.sv
// Bench for e203_ifu_flush_ctrl: adder build (16-bit counter) and flush-pc build (2-bit counter) in lockstep.
module tb_e203_ifu_flush_ctrl;

    typedef struct packed {
        logic [31:0] pc_add;
        logic [31:0] pc_pre;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        pending;
    logic        ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] fpc;

    logic        a_ack, a_hold, a_kill, a_valid;
    logic [31:0] a_pc;
    logic [15:0] a_cnt;
    logic        b_ack, b_hold, b_kill, b_valid;
    logic [31:0] b_pc;
    logic [1:0]  b_cnt;

    int   n_checks  = 0;
    int   n_errors  = 0;
    bit   started   = 1'b0;
    int   exp_cnt_a = 0;
    int   exp_cnt_b = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    e203_ifu_flush_ctrl #(
        .PC_SIZE      (32),
        .USE_FLUSH_PC (0),
        .CNT_W        (16)
    ) dut_add (
        .clk                (clk),
        .rst                (rst),
        .pipe_flush_req     (req),
        .pipe_flush_add_op1 (op1),
        .pipe_flush_add_op2 (op2),
        .pipe_flush_pc      (fpc),
        .pipe_flush_ack     (a_ack),
        .ifu_rsp_pending    (pending),
        .ifu_hold           (a_hold),
        .ifu_rsp_kill       (a_kill),
        .redirect_valid     (a_valid),
        .redirect_pc        (a_pc),
        .redirect_ready     (ready),
        .flush_count        (a_cnt)
    );

    e203_ifu_flush_ctrl #(
        .PC_SIZE      (32),
        .USE_FLUSH_PC (1),
        .CNT_W        (2)
    ) dut_pre (
        .clk                (clk),
        .rst                (rst),
        .pipe_flush_req     (req),
        .pipe_flush_add_op1 (op1),
        .pipe_flush_add_op2 (op2),
        .pipe_flush_pc      (fpc),
        .pipe_flush_ack     (b_ack),
        .ifu_rsp_pending    (pending),
        .ifu_hold           (b_hold),
        .ifu_rsp_kill       (b_kill),
        .redirect_valid     (b_valid),
        .redirect_pc        (b_pc),
        .redirect_ready     (ready),
        .flush_count        (b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic ack, input logic hold,
                              input logic kill, input logic valid);
        check({tag, "_ack_a"},   {31'b0, a_ack},   {31'b0, ack});
        check({tag, "_hold_a"},  {31'b0, a_hold},  {31'b0, hold});
        check({tag, "_kill_a"},  {31'b0, a_kill},  {31'b0, kill});
        check({tag, "_valid_a"}, {31'b0, a_valid}, {31'b0, valid});
        check({tag, "_ack_b"},   {31'b0, b_ack},   {31'b0, ack});
        check({tag, "_hold_b"},  {31'b0, b_hold},  {31'b0, hold});
        check({tag, "_kill_b"},  {31'b0, b_kill},  {31'b0, kill});
        check({tag, "_valid_b"}, {31'b0, b_valid}, {31'b0, valid});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push the expected target on each accept, compare while the redirect is offered.
    always @(negedge clk) begin
        if (started) begin
            check("cnt_a", {16'b0, a_cnt}, 32'(exp_cnt_a));
            check("cnt_b", {30'b0, b_cnt}, 32'(exp_cnt_b));
            if (a_valid || b_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_redirect", {31'b0, a_valid | b_valid}, 32'd0);
                end else begin
                    check("sb_pc_a", a_pc, sb_q[0].pc_add);
                    check("sb_pc_b", b_pc, sb_q[0].pc_pre);
                    if (ready) begin
                        void'(sb_q.pop_front());
                    end
                end
            end
            if (rst) begin
                sb_q.delete();
                exp_cnt_a = 0;
                exp_cnt_b = 0;
            end else if (req && a_ack) begin
                sb_q.push_back(exp_t'{pc_add: op1 + op2, pc_pre: fpc});
                if (exp_cnt_a < 65535) exp_cnt_a++;
                if (exp_cnt_b < 3)     exp_cnt_b++;
            end
        end
    end

    initial begin
        rst     = 1'b1;
        req     = 1'b0;
        pending = 1'b0;
        ready   = 1'b0;
        op1     = '0;
        op2     = '0;
        fpc     = '0;
        repeat (2) cycle();
        started = 1'b1;
        rst     = 1'b0;

        check_ctrl("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_pc_a", a_pc, 32'h0);
        check("reset_pc_b", b_pc, 32'h0);
        check("reset_cnt_a", {16'b0, a_cnt}, 32'd0);

        // Basic flush: 2-cycle request-to-redirect latency.
        op1 = 32'h8000_0000; op2 = 32'h0000_0010; fpc = 32'h1234_5678;
        ready = 1'b1; req = 1'b1;
        check_ctrl("basic_t0", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(); req = 1'b0;
        check_ctrl("basic_t1", 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        check_ctrl("basic_t2", 1'b0, 1'b1, 1'b1, 1'b1);
        check("basic_pc_a", a_pc, 32'h8000_0010);
        check("basic_pc_b", b_pc, 32'h1234_5678);
        cycle();
        check_ctrl("basic_t3", 1'b1, 1'b0, 1'b0, 1'b0);
        check("basic_cnt_a", {16'b0, a_cnt}, 32'd1);

        // Drain: pending held for 4 cycles after accept.
        op1 = 32'h0000_1000; op2 = 32'h0000_0200; fpc = 32'hABCD_0000;
        pending = 1'b1; req = 1'b1;
        cycle(); req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_ctrl($sformatf("drain_%0d", i), 1'b0, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        pending = 1'b0;
        check_ctrl("drain_fall", 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        check_ctrl("drain_redirect", 1'b0, 1'b1, 1'b1, 1'b1);
        check("drain_pc_a", a_pc, 32'h0000_1200);
        cycle();
        check_ctrl("drain_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // Backpressure with wrapping target; a second request waits for IDLE.
        ready = 1'b0;
        op1 = 32'hFFFF_FFFC; op2 = 32'h0000_0008; fpc = 32'h0000_0040; req = 1'b1;
        cycle();
        op1 = 32'h0000_2000; op2 = 32'h0000_0004; fpc = 32'h0000_0080;
        check_ctrl("bp_drain", 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            check_ctrl($sformatf("bp_hold_%0d", i), 1'b0, 1'b1, 1'b1, 1'b1);
            check("bp_pc_a", a_pc, 32'h0000_0004);
            check("bp_pc_b", b_pc, 32'h0000_0040);
            cycle();
        end
        ready = 1'b1;
        check_ctrl("bp_release", 1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        check_ctrl("bp_second_accept", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(); req = 1'b0;
        check_ctrl("bp2_drain", 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        check_ctrl("bp2_redirect", 1'b0, 1'b1, 1'b1, 1'b1);
        check("bp2_pc_a", a_pc, 32'h0000_2004);
        check("bp2_pc_b", b_pc, 32'h0000_0080);
        cycle();
        check_ctrl("bp2_idle", 1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_cnt_b_4", {30'b0, b_cnt}, 32'd3);

        // Back-to-back flushes every 3 cycles; 2-bit counter stays saturated.
        for (int i = 0; i < 3; i++) begin
            op1 = 32'(i) << 8; op2 = 32'h4; fpc = 32'h100 + 32'(i); req = 1'b1;
            check($sformatf("b2b_ack_%0d", i), {31'b0, a_ack}, 32'd1);
            cycle(); req = 1'b0;
            cycle();
            check($sformatf("b2b_pc_a_%0d", i), a_pc, (32'(i) << 8) + 32'h4);
            cycle();
        end
        check("sat_cnt_a_7", {16'b0, a_cnt}, 32'd7);
        check("sat_cnt_b_7", {30'b0, b_cnt}, 32'd3);

        // Reset in DRAIN abandons the flush.
        op1 = 32'h0000_5000; op2 = 32'h0; fpc = 32'h0000_6000;
        req = 1'b1; pending = 1'b1;
        cycle(); req = 1'b0;
        check_ctrl("rst_pre", 1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cycle();
        check_ctrl("rst_post", 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_cnt_a", {16'b0, a_cnt}, 32'd0);
        check("rst_cnt_b", {30'b0, b_cnt}, 32'd0);
        check("rst_pc_a", a_pc, 32'h0);
        rst = 1'b0; pending = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rst_no_redirect_%0d", i), {31'b0, a_valid | b_valid}, 32'd0);
            cycle();
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
